// File: rtl/spi_slave_shifter_pkg.sv
// Shared types and constants for the SPI mode-0 slave shifter.
// Optional build macro used by the datapath: SPI_LSB_FIRST_EN (LSB-first framing).
package spi_pkg;

   // Frame state: IDLE while chip select is high, ACTIVE while a frame runs.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   // Default word width.
   localparam int SPI_DATA_W_DEF = 8;

   // Widest word the idle-fill helper can describe.
   localparam int SPI_FILL_MAX_W = 64;

   // Word shifted out when no transmit data is offered: all ones in the
   // low 'width' bits. Callers truncate the result to their own width.
   function automatic logic [SPI_FILL_MAX_W-1:0] spi_idle_fill(input int width);
      if (width >= SPI_FILL_MAX_W)
         spi_idle_fill = '1;
      else
         spi_idle_fill = (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Bus bundle between the SPI slave shifter and its surroundings.
// The slave modport is the shifter's view; master is the SPI pins plus the
// downstream word interface as seen from outside.
interface spi_slave_shifter_if
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W_DEF
);
   logic              cs_n;
   logic              sclk_posedge;
   logic              sclk_negedge;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_abort;

   modport slave (
      input  cs_n, sclk_posedge, sclk_negedge, mosi, tx_data, tx_valid,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_abort
   );

   modport master (
      output cs_n, sclk_posedge, sclk_negedge, mosi, tx_data, tx_valid,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_abort
   );

endinterface

// File: rtl/spi_slave_shifter_bit_counter.sv
// Bit position counter for one SPI word: counts 0..DATA_W-1 and wraps.
// 'wrap' flags the enable that completes a word (combinational).
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W_DEF,
   localparam int CNT_W = $clog2(DATA_W)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   assign wrap = en && (cnt == LAST);

   // Count received bits; clear wins over enable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave datapath driven by single-cycle SCLK edge pulses in the
// clk domain. Receives MOSI words, transmits MISO words, frames on cs_n.
// Build macro SPI_LSB_FIRST_EN selects LSB-first order on both lines;
// without it words travel MSB-first.
module spi_slave_shifter
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W_DEF,
   localparam int CNT_W = $clog2(DATA_W)
) (
   input logic                 clk,
   input logic                 rstn,
   spi_slave_shifter_if.slave  bus
);

   localparam logic [DATA_W-1:0] IDLE_FILL = DATA_W'(spi_idle_fill(DATA_W));

   spi_state_e        state_q, state_d;
   logic              word_done_q;
   logic [DATA_W-2:0] rx_shift_q;   // most recent DATA_W-1 bits; last bit completes the word
   logic [DATA_W-1:0] tx_shift_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              abort_q;

   logic              do_load;
   logic              do_shift_tx;
   logic              cnt_clr;
   logic              cnt_en;
   logic              cnt_wrap;
   logic              abort_d;
   logic [CNT_W-1:0]  bit_cnt;

   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_next;
   logic              tx_bit;

`ifdef SPI_LSB_FIRST_EN
   assign rx_next = {bus.mosi, rx_shift_q};
   assign tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
   assign tx_bit  = tx_shift_q[0];
`else
   assign rx_next = {rx_shift_q, bus.mosi};
   assign tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
   assign tx_bit  = tx_shift_q[DATA_W-1];
`endif

   spi_bit_counter #(.DATA_W(DATA_W)) u_bit_counter (
      .clk  (clk),
      .rstn (rstn),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (bit_cnt),
      .wrap (cnt_wrap)
   );

   // Next-state and per-cycle actions; cs_n beats SCLK, posedge beats negedge.
   always_comb begin
      state_d     = state_q;
      do_load     = 1'b0;
      do_shift_tx = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      abort_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.cs_n) begin
               state_d = ACTIVE;
               do_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (bus.cs_n) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
               abort_d = (bit_cnt != '0);
            end else if (bus.sclk_posedge) begin
               cnt_en = 1'b1;
            end else if (bus.sclk_negedge) begin
               if (word_done_q)
                  do_load = 1'b1;
               else
                  do_shift_tx = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame state, word-complete flag, received word and output pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         word_done_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_valid_q <= cnt_wrap;
         abort_q    <= abort_d;
         if (cnt_clr || do_load)
            word_done_q <= 1'b0;
         else if (cnt_wrap)
            word_done_q <= 1'b1;
         if (cnt_wrap)
            rx_data_q <= rx_next;
      end
   end

   // Receive and transmit shift registers; a partial rx word is dropped on cs_n rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_shift_q <= '0;
         tx_shift_q <= '0;
      end else begin
         if (cnt_clr)
            rx_shift_q <= '0;
         else if (cnt_en)
`ifdef SPI_LSB_FIRST_EN
            rx_shift_q <= rx_next[DATA_W-1:1];
`else
            rx_shift_q <= rx_next[DATA_W-2:0];
`endif
         if (do_load)
            tx_shift_q <= bus.tx_valid ? bus.tx_data : IDLE_FILL;
         else if (do_shift_tx)
            tx_shift_q <= tx_next;
      end
   end

   // tx_ready is combinational so the handshake completes on the loading edge.
   assign bus.tx_ready    = do_load && bus.tx_valid;
   assign bus.miso        = (state_q == ACTIVE) ? tx_bit : 1'b0;
   assign bus.miso_oe     = (state_q == ACTIVE);
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.frame_abort = abort_q;

endmodule
